ppu_vram_cntr: RTL and testbench

//  Live VRAM address counters of the PPU, downstream of the register interface.

---
 rtl/ppu_vram_cntr_if.sv | 40 ++++
 rtl/ppu_vram_cntr.sv | 151 +++++++++++++++
 tb/tb_ppu_vram_cntr.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ppu_vram_cntr_if.sv
`default_nettype none
// ============================================================================
// Module  : ppu_vram_cntr_if
// Brief   : Scroll latch / control inputs and VRAM address outputs of the
//           PPU live address counters.
// Revision: 1.0 - initial release
// ============================================================================
interface ppu_vram_cntr_if;
    logic [2:0]  fv_in;
    logic [4:0]  vt_in;
    logic        v_in;
    logic [4:0]  ht_in;
    logic        h_in;
    logic        upd_cntrs_in;
    logic        inc_addr_in;
    logic        inc_addr_amt_in;
    logic        render_en_in;
    logic        pix_pulse_in;
    logic [9:0]  nes_x_in;
    logic [9:0]  nes_y_in;
    logic [13:0] vram_a_out;
    logic [13:0] nt_a_out;
    logic [13:0] at_a_out;
    logic [2:0]  fv_out;

    modport master (
        output fv_in, vt_in, v_in, ht_in, h_in,
        output upd_cntrs_in, inc_addr_in, inc_addr_amt_in,
        output render_en_in, pix_pulse_in, nes_x_in, nes_y_in,
        input  vram_a_out, nt_a_out, at_a_out, fv_out
    );

    modport slave (
        input  fv_in, vt_in, v_in, ht_in, h_in,
        input  upd_cntrs_in, inc_addr_in, inc_addr_amt_in,
        input  render_en_in, pix_pulse_in, nes_x_in, nes_y_in,
        output vram_a_out, nt_a_out, at_a_out, fv_out
    );
endinterface
`default_nettype wire

// File: rtl/ppu_vram_cntr.sv
`default_nettype none
// ============================================================================
// Module  : ppu_vram_cntr
// Brief   : PPU live VRAM address counters: latch loads, 0x2007 stepping and
//           the rendering walk, decoded into CPU/nametable/attribute addresses.
// Revision: 1.0 - initial release
// ============================================================================
module ppu_vram_cntr #(
    parameter int PRE_Y = 261,
    parameter int VIS_Y = 240
) (
    input  logic             clk_in,
    input  logic             rst_in,
    ppu_vram_cntr_if.slave   bus
);
    localparam logic [9:0] c_pre_y = 10'(PRE_Y);
    localparam logic [9:0] c_vis_y = 10'(VIS_Y);

    logic [2:0]  r_cfv;
    logic [4:0]  r_cvt;
    logic        r_cv;
    logic        r_ch;
    logic [4:0]  r_cht;

    logic [2:0]  w_cfv;
    logic [4:0]  w_cvt;
    logic        w_cv;
    logic        w_ch;
    logic [4:0]  w_cht;

    logic        w_rend;
    logic        w_dot_ok;
    logic        w_x_tile;
    logic        w_y_step;
    logic        w_h_reload;
    logic        w_v_reload;

    logic        w_cx_h;
    logic [4:0]  w_cx_ht;
    logic [2:0]  w_yi_fv;
    logic [4:0]  w_yi_vt;
    logic        w_yi_v;
    logic [14:0] w_addr_inc;

    assign w_rend   = bus.render_en_in &
                      ((bus.nes_y_in < c_vis_y) || (bus.nes_y_in == c_pre_y));
    assign w_dot_ok = bus.pix_pulse_in & w_rend;

    // Tile fetch boundaries: every 8th dot of the visible span plus the two prefetch tiles.
    assign w_x_tile   = (bus.nes_x_in[2:0] == 3'd0) &&
                        (((bus.nes_x_in >= 10'd8)   && (bus.nes_x_in <= 10'd256)) ||
                         ((bus.nes_x_in >= 10'd328) && (bus.nes_x_in <= 10'd336)));
    assign w_y_step   = (bus.nes_x_in == 10'd256);
    assign w_h_reload = (bus.nes_x_in == 10'd257);
    assign w_v_reload = (bus.nes_y_in == c_pre_y) &&
                        (bus.nes_x_in >= 10'd280) && (bus.nes_x_in <= 10'd304);

    // Coarse X rolls from tile 31 into the neighbouring horizontal nametable.
    assign {w_cx_h, w_cx_ht} = {r_ch, r_cht} + 6'd1;

    assign w_addr_inc = {r_cfv, r_cv, r_ch, r_cvt, r_cht} +
                        (bus.inc_addr_amt_in ? 15'd32 : 15'd1);

    // Rows 30/31 are attribute space: 29 wraps into the next nametable, 31 wraps in place.
    always_comb begin
        w_yi_fv = r_cfv;
        w_yi_vt = r_cvt;
        w_yi_v  = r_cv;
        if (r_cfv != 3'd7) begin
            w_yi_fv = r_cfv + 3'd1;
        end else begin
            w_yi_fv = 3'd0;
            if (r_cvt == 5'd29) begin
                w_yi_vt = 5'd0;
                w_yi_v  = ~r_cv;
            end else if (r_cvt == 5'd31) begin
                w_yi_vt = 5'd0;
            end else begin
                w_yi_vt = r_cvt + 5'd1;
            end
        end
    end

    always_comb begin
        w_cfv = r_cfv;
        w_cvt = r_cvt;
        w_cv  = r_cv;
        w_ch  = r_ch;
        w_cht = r_cht;
        if (bus.upd_cntrs_in) begin
            w_cfv = bus.fv_in;
            w_cvt = bus.vt_in;
            w_cv  = bus.v_in;
            w_ch  = bus.h_in;
            w_cht = bus.ht_in;
        end else if (bus.inc_addr_in) begin
            if (w_rend) begin
                // A 0x2007 access mid-render glitches both counters like the real chip.
                w_ch  = w_cx_h;
                w_cht = w_cx_ht;
                w_cfv = w_yi_fv;
                w_cvt = w_yi_vt;
                w_cv  = w_yi_v;
            end else begin
                {w_cfv, w_cv, w_ch, w_cvt, w_cht} = w_addr_inc;
            end
        end else if (w_dot_ok) begin
            if (w_x_tile) begin
                w_ch  = w_cx_h;
                w_cht = w_cx_ht;
            end
            if (w_y_step) begin
                w_cfv = w_yi_fv;
                w_cvt = w_yi_vt;
                w_cv  = w_yi_v;
            end
            if (w_h_reload) begin
                w_ch  = bus.h_in;
                w_cht = bus.ht_in;
            end
            if (w_v_reload) begin
                w_cfv = bus.fv_in;
                w_cvt = bus.vt_in;
                w_cv  = bus.v_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cfv <= 3'd0;
            r_cvt <= 5'd0;
            r_cv  <= 1'b0;
            r_ch  <= 1'b0;
            r_cht <= 5'd0;
        end else begin
            r_cfv <= w_cfv;
            r_cvt <= w_cvt;
            r_cv  <= w_cv;
            r_ch  <= w_ch;
            r_cht <= w_cht;
        end
    end

    assign bus.vram_a_out = {r_cfv[1:0], r_cv, r_ch, r_cvt, r_cht};
    assign bus.nt_a_out   = {2'b10, r_cv, r_ch, r_cvt, r_cht};
    assign bus.at_a_out   = {2'b10, r_cv, r_ch, 4'b1111, r_cvt[4:2], r_cht[4:2]};
    assign bus.fv_out     = r_cfv;

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_cntr.sv
`default_nettype none
// ============================================================================
// Module  : tb_ppu_vram_cntr
// Brief   : Directed vector table, hand sequences and randomized run against
//           a field-level reference model of the PPU VRAM address counters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ppu_vram_cntr;
    logic clk;
    logic rst;

    ppu_vram_cntr_if bus ();

    ppu_vram_cntr #(.PRE_Y(261), .VIS_Y(240)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, upd, inc, amt, ren, pix;
        int          x, y;
        int          fv, vt, v, h, ht;
        int          exp_vram, exp_at, exp_fv;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int m_fv, m_vt, m_v, m_h, m_ht;

    function automatic vec_t mk(input logic r, u, i, a, re, p, input int x, y,
                                input int fv, vt, v, h, ht, ev, ea, ef);
        vec_t t;
        t.rst = r; t.upd = u; t.inc = i; t.amt = a; t.ren = re; t.pix = p;
        t.x = x; t.y = y; t.fv = fv; t.vt = vt; t.v = v; t.h = h; t.ht = ht;
        t.exp_vram = ev; t.exp_at = ea; t.exp_fv = ef;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, u, i, a, re, p, input int x, y,
                         input int fv, vt, v, h, ht);
        rst                 = r;
        bus.upd_cntrs_in    = u;
        bus.inc_addr_in     = i;
        bus.inc_addr_amt_in = a;
        bus.render_en_in    = re;
        bus.pix_pulse_in    = p;
        bus.nes_x_in        = 10'(x);
        bus.nes_y_in        = 10'(y);
        bus.fv_in           = 3'(fv);
        bus.vt_in           = 5'(vt);
        bus.v_in            = 1'(v);
        bus.h_in            = 1'(h);
        bus.ht_in           = 5'(ht);
    endtask

    // Reference: counters as plain integers, address stepping as 15-bit arithmetic.
    task automatic coarse_x();
        int hx;
        hx   = (m_h * 32 + m_ht + 1) % 64;
        m_h  = hx / 32;
        m_ht = hx % 32;
    endtask

    task automatic y_inc();
        if (m_fv < 7) m_fv = m_fv + 1;
        else begin
            m_fv = 0;
            if (m_vt == 29) begin m_vt = 0; m_v = 1 - m_v; end
            else if (m_vt == 31) m_vt = 0;
            else m_vt = m_vt + 1;
        end
    endtask

    task automatic model_step();
        int x, y, a;
        bit rend;
        x = int'(bus.nes_x_in);
        y = int'(bus.nes_y_in);
        rend = bus.render_en_in && (y < 240 || y == 261);
        if (rst) begin
            m_fv = 0; m_vt = 0; m_v = 0; m_h = 0; m_ht = 0;
        end else if (bus.upd_cntrs_in) begin
            m_fv = int'(bus.fv_in); m_vt = int'(bus.vt_in); m_v = int'(bus.v_in);
            m_h = int'(bus.h_in); m_ht = int'(bus.ht_in);
        end else if (bus.inc_addr_in) begin
            if (rend) begin
                coarse_x();
                y_inc();
            end else begin
                a = m_fv * 4096 + m_v * 2048 + m_h * 1024 + m_vt * 32 + m_ht;
                a = (a + (bus.inc_addr_amt_in ? 32 : 1)) % 32768;
                m_fv = a / 4096; m_v = (a / 2048) % 2; m_h = (a / 1024) % 2;
                m_vt = (a / 32) % 32; m_ht = a % 32;
            end
        end else if (bus.pix_pulse_in && rend) begin
            if (x % 8 == 0 && ((x >= 8 && x <= 256) || (x >= 328 && x <= 336))) coarse_x();
            if (x == 256) y_inc();
            if (x == 257) begin m_ht = int'(bus.ht_in); m_h = int'(bus.h_in); end
            if (y == 261 && x >= 280 && x <= 304) begin
                m_fv = int'(bus.fv_in); m_vt = int'(bus.vt_in); m_v = int'(bus.v_in);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int base;
        base = m_v * 2048 + m_h * 1024;
        check({tag, " vram_a"}, int'(bus.vram_a_out), (m_fv % 4) * 4096 + base + m_vt * 32 + m_ht);
        check({tag, " nt_a"}, int'(bus.nt_a_out), 'h2000 + base + m_vt * 32 + m_ht);
        check({tag, " at_a"}, int'(bus.at_a_out), 'h23C0 + base + (m_vt / 4) * 8 + m_ht / 4);
        check({tag, " fv"}, int'(bus.fv_out), m_fv);
    endtask

    vec_t tbl[26];

    initial begin
        tbl[0]  = mk(1,0,0,0,0,0,   0,  0, 0, 0,0,0, 0, 'h0000,'h23C0,0);
        tbl[1]  = mk(0,1,0,0,0,0,   0,  0, 3,31,1,0,21, 'h3BF5,'h2BFD,3);
        tbl[2]  = mk(0,0,1,1,0,0,   0,  0, 0, 0,0,0, 0, 'h3C15,'h2FC5,3);
        tbl[3]  = mk(0,1,0,0,0,0,   0,  0, 7,31,1,1,31, 'h3FFF,'h2FFF,7);
        tbl[4]  = mk(0,0,1,0,0,0,   0,  0, 0, 0,0,0, 0, 'h0000,'h23C0,0);
        tbl[5]  = mk(0,1,0,0,0,0,   0,  0, 0, 0,0,0,31, 'h001F,'h23C7,0);
        tbl[6]  = mk(0,0,0,0,1,1,   8, 10, 0, 0,0,0, 0, 'h0400,'h27C0,0);
        tbl[7]  = mk(0,0,0,0,1,1, 257, 10, 0, 0,0,0, 5, 'h0005,'h23C1,0);
        tbl[8]  = mk(0,0,0,0,1,0, 264, 10, 0, 0,0,0, 0, 'h0005,'h23C1,0);
        tbl[9]  = mk(0,0,0,0,1,1,   9, 10, 0, 0,0,0, 0, 'h0005,'h23C1,0);
        tbl[10] = mk(0,1,0,0,0,0,   0,  0, 7,29,0,0, 3, 'h33A3,'h23F8,7);
        tbl[11] = mk(0,0,0,0,1,1, 256, 10, 0, 0,0,0, 0, 'h0804,'h2BC1,0);
        tbl[12] = mk(0,1,0,0,0,0,   0,  0, 7,31,0,0, 3, 'h33E3,'h23F8,7);
        tbl[13] = mk(0,0,0,0,1,1, 256, 10, 0, 0,0,0, 0, 'h0004,'h23C1,0);
        tbl[14] = mk(0,1,0,0,0,0,   0,  0, 5, 2,0,0, 0, 'h1040,'h23C0,5);
        tbl[15] = mk(0,0,0,0,1,1, 256, 10, 0, 0,0,0, 0, 'h2041,'h23C0,6);
        tbl[16] = mk(0,0,0,0,1,1, 290,261, 2, 4,1,1, 9, 'h2881,'h2BC8,2);
        tbl[17] = mk(0,1,0,0,1,1, 290,261, 1, 6,0,1, 7, 'h14C7,'h27C9,1);
        tbl[18] = mk(0,0,0,0,0,1, 290,261, 3, 9,1,0, 2, 'h14C7,'h27C9,1);
        tbl[19] = mk(0,0,0,0,1,1, 256,245, 3, 9,1,0, 2, 'h14C7,'h27C9,1);
        tbl[20] = mk(0,0,1,1,1,0,   0, 10, 0, 0,0,0, 0, 'h24C8,'h27CA,2);
        tbl[21] = mk(0,1,1,1,1,1, 256, 10, 0, 0,0,0, 0, 'h0000,'h23C0,0);
        tbl[22] = mk(1,1,1,0,0,0,   0,  0, 7,31,1,1,31, 'h0000,'h23C0,0);
        tbl[23] = mk(0,0,0,0,1,1, 336,  0, 0, 0,0,0, 0, 'h0001,'h23C0,0);
        tbl[24] = mk(0,0,0,0,1,1, 320,  0, 0, 0,0,0, 0, 'h0001,'h23C0,0);
        tbl[25] = mk(0,0,0,0,1,1, 328,239, 0, 0,0,0, 0, 'h0002,'h23C0,0);

        m_fv = 0; m_vt = 0; m_v = 0; m_h = 0; m_ht = 0;
        drive(1,0,0,0,0,0, 0,0, 0,0,0,0,0);
        #2;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].upd, tbl[i].inc, tbl[i].amt, tbl[i].ren, tbl[i].pix,
                  tbl[i].x, tbl[i].y, tbl[i].fv, tbl[i].vt, tbl[i].v, tbl[i].h, tbl[i].ht);
            cycle();
            check($sformatf("vec%0d vram_a", i), int'(bus.vram_a_out), tbl[i].exp_vram);
            check($sformatf("vec%0d at_a", i), int'(bus.at_a_out), tbl[i].exp_at);
            check($sformatf("vec%0d fv", i), int'(bus.fv_out), tbl[i].exp_fv);
        end

        // Render disabled across a whole pre-render line: counters must hold.
        drive(0,1,0,0,0,0, 0,0, 4,9,1,1,17);
        cycle();
        for (int x = 0; x <= 340; x++) begin
            drive(0,0,0,0,0,1, x,261, 7,3,0,0,2);
            cycle();
        end
        check("render_off_line vram_a", int'(bus.vram_a_out), 'h0D31);
        check("render_off_line fv", int'(bus.fv_out), 4);

        // Vertical reload on every pre-render dot 280..304, none at 305.
        for (int x = 280; x <= 305; x++) begin
            drive(0,0,0,0,1,1, x,261, 1,(x * 7) % 32,0,0,0);
            cycle();
            check($sformatf("vreload x%0d vt", x), int'(bus.nt_a_out[9:5]),
                  (x <= 304) ? (x * 7) % 32 : (304 * 7) % 32);
        end
        check_model("vreload");

        for (int n = 0; n < 3000; n++) begin
            int x, y, sel;
            int xl[12] = '{8, 16, 256, 257, 280, 292, 304, 305, 328, 336, 337, 0};
            sel = int'($urandom_range(0, 3));
            x = (sel < 2) ? xl[$urandom_range(0, 11)] : int'($urandom_range(0, 340));
            sel = int'($urandom_range(0, 3));
            y = (sel == 0) ? 261 : (sel == 1) ? int'($urandom_range(0, 261)) : int'($urandom_range(0, 239));
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 10), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 70),
                  x, y, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)));
            cycle();
            check_model($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
